// File: rtl/rc4_prga_engine.sv
// RC4 keystream generator: swaps S in place, XORs ciphertext with keystream and writes plaintext.
// Latency: 10+3*RAM_LAT cycles per byte; done pulses one cycle after the last plaintext write.
// Backpressure: none; start is sampled only in IDLE, and a validity failure aborts the pass via reject.
module rc4_prga_engine #(
  parameter int unsigned MSG_LEN  = 32,
  parameter int unsigned RAM_LAT  = 1,
  parameter bit          CHECK_EN = 1'b1,
  parameter int unsigned CHAR_LO  = 97,
  parameter int unsigned CHAR_HI  = 122
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       reject,
  output logic [7:0] fail_index,
  output logic [7:0] s_addr,
  output logic [7:0] s_wdata,
  output logic       s_wren,
  input  logic [7:0] s_rdata,
  output logic [7:0] msg_addr,
  input  logic [7:0] msg_rdata,
  output logic [7:0] out_addr,
  output logic [7:0] out_wdata,
  output logic       out_wren
);

  typedef enum logic [3:0] {
    IDLE, NEXT_I, RD_SI, CALC_J, RD_SJ, WR_SI, WR_SJ, RD_F, XOR, CHECK, WR_OUT, DONE, REJECT
  } state_t;

  // Read states last RAM_LAT+1 cycles: one cycle to present the address, RAM_LAT to wait.
  localparam logic [2:0] LAT    = 3'(RAM_LAT);
  localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);
  localparam logic [7:0] LO     = 8'(CHAR_LO);
  localparam logic [7:0] HI     = 8'(CHAR_HI);

  state_t     state, state_d;
  logic [7:0] i, j, k, si, sj, f, ct, pt;
  logic [7:0] i_d, j_d, k_d, si_d, sj_d, f_d, ct_d, pt_d, fail_d;
  logic [2:0] cnt, cnt_d;
  logic       pt_ok;
  logic [7:0] s_addr_d, s_wdata_d, msg_addr_d, out_addr_d, out_wdata_d;
  logic       s_wren_d, out_wren_d, busy_d, done_d, reject_d;

  // Next-state and datapath updates, then the registered outputs for the state being entered.
  always_comb begin
    state_d = state;
    i_d     = i;
    j_d     = j;
    k_d     = k;
    si_d    = si;
    sj_d    = sj;
    f_d     = f;
    ct_d    = ct;
    pt_d    = pt;
    cnt_d   = cnt;
    fail_d  = fail_index;
    pt_ok   = (pt == 8'd32) || ((pt >= LO) && (pt <= HI));

    case (state)
      IDLE: begin
        i_d = 8'd0;
        j_d = 8'd0;
        k_d = 8'd0;
        if (start) begin
          state_d = NEXT_I;
          fail_d  = 8'd0;
        end
      end
      NEXT_I: begin
        i_d     = i + 8'd1;
        cnt_d   = 3'd0;
        state_d = RD_SI;
      end
      RD_SI: begin
        if (cnt == LAT) begin
          si_d    = s_rdata;
          state_d = CALC_J;
        end else begin
          cnt_d = cnt + 3'd1;
        end
      end
      CALC_J: begin
        j_d     = j + si;
        cnt_d   = 3'd0;
        state_d = RD_SJ;
      end
      RD_SJ: begin
        if (cnt == LAT) begin
          sj_d    = s_rdata;
          state_d = WR_SI;
        end else begin
          cnt_d = cnt + 3'd1;
        end
      end
      WR_SI: state_d = WR_SJ;
      WR_SJ: begin
        cnt_d   = 3'd0;
        state_d = RD_F;
      end
      RD_F: begin
        if (cnt == LAT) begin
          f_d     = s_rdata;
          ct_d    = msg_rdata;
          state_d = XOR;
        end else begin
          cnt_d = cnt + 3'd1;
        end
      end
      XOR: begin
        pt_d    = ct ^ f;
        state_d = CHECK;
      end
      CHECK: begin
        if (!CHECK_EN || pt_ok) begin
          state_d = WR_OUT;
        end else begin
          fail_d  = k;
          state_d = REJECT;
        end
      end
      WR_OUT: begin
        k_d     = k + 8'd1;
        state_d = (k == LAST_K) ? DONE : NEXT_I;
      end
      DONE:    state_d = IDLE;
      REJECT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Addresses hold between accesses; enables and pulses are high only in their own state.
    s_addr_d    = s_addr;
    s_wdata_d   = s_wdata;
    s_wren_d    = 1'b0;
    msg_addr_d  = msg_addr;
    out_addr_d  = out_addr;
    out_wdata_d = out_wdata;
    out_wren_d  = 1'b0;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    reject_d    = (state_d == REJECT);

    case (state_d)
      RD_SI: s_addr_d = i_d;
      RD_SJ: s_addr_d = j_d;
      WR_SI: begin
        s_addr_d  = i_d;
        s_wdata_d = sj_d;
        s_wren_d  = 1'b1;
      end
      WR_SJ: begin
        s_addr_d  = j_d;
        s_wdata_d = si_d;
        s_wren_d  = 1'b1;
      end
      RD_F: begin
        s_addr_d   = si_d + sj_d;
        msg_addr_d = k_d;
      end
      WR_OUT: begin
        out_addr_d  = k_d;
        out_wdata_d = pt_d;
        out_wren_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      i          <= 8'd0;
      j          <= 8'd0;
      k          <= 8'd0;
      si         <= 8'd0;
      sj         <= 8'd0;
      f          <= 8'd0;
      ct         <= 8'd0;
      pt         <= 8'd0;
      cnt        <= 3'd0;
      fail_index <= 8'd0;
      s_addr     <= 8'd0;
      s_wdata    <= 8'd0;
      s_wren     <= 1'b0;
      msg_addr   <= 8'd0;
      out_addr   <= 8'd0;
      out_wdata  <= 8'd0;
      out_wren   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      reject     <= 1'b0;
    end else begin
      state      <= state_d;
      i          <= i_d;
      j          <= j_d;
      k          <= k_d;
      si         <= si_d;
      sj         <= sj_d;
      f          <= f_d;
      ct         <= ct_d;
      pt         <= pt_d;
      cnt        <= cnt_d;
      fail_index <= fail_d;
      s_addr     <= s_addr_d;
      s_wdata    <= s_wdata_d;
      s_wren     <= s_wren_d;
      msg_addr   <= msg_addr_d;
      out_addr   <= out_addr_d;
      out_wdata  <= out_wdata_d;
      out_wren   <= out_wren_d;
      busy       <= busy_d;
      done       <= done_d;
      reject     <= reject_d;
    end
  end

endmodule
